// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the register write-back stage.
//   WB_DEPTH / WB_AW / WB_DW : default queue depth, address width, data width
//   wb_entry_t               : one memory-result queue slot {live, addr, data}
//   count_width()            : width of an occupancy counter able to hold 0..depth
// Optional feature macro used by the stage: WB_ZERO_DISCARD_EN.
package wb_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_AW    = 5;
    localparam int WB_DW    = 32;

    typedef struct packed {
        logic             live;
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wb_queue.sv
// wb_queue: in-order circular queue of wb_entry_t for buffered memory results.
//   clk, rst_n  : clock, synchronous active-low reset (clears every slot)
//   push        : store push_entry at the tail
//   pop         : retire the head slot (its live bit is cleared as it leaves)
//   kill        : clear the live bit of every slot whose addr equals kill_addr
//   head        : current head slot
//   count       : occupancy, live and killed slots alike
//   live / addr : per-slot live flag and destination, for scoreboard decode
module wb_queue
    import wb_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    input  logic                         kill,
    input  logic [WB_AW-1:0]             kill_addr,
    output wb_entry_t                    head,
    output logic [CW-1:0]                count,
    output logic [DEPTH-1:0]             live,
    output logic [DEPTH-1:0][WB_AW-1:0] addr
);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (kill) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (mem[i].live && (mem[i].addr == kill_addr)) begin
                        mem[i].live <= 1'b0;
                    end
                end
            end
            // Clearing live on pop drops the slot out of the scoreboard at once.
            if (pop) begin
                mem[head_ptr].live <= 1'b0;
                head_ptr           <= head_ptr + PW'(1);
            end
            if (push) begin
                mem[tail_ptr] <= push_entry;
                tail_ptr      <= tail_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head = mem[head_ptr];

    always_comb begin
        live = '0;
        addr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            live[i] = mem[i].live;
            addr[i] = mem[i].addr;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: write-back stage driving the register bank write port.
//   clk, rst_n                   : clock, synchronous active-low reset
//   AluValid/AluAddr/AluData     : single-cycle ALU result, written next cycle
//   MemValid/MemAddr/MemData     : memory result offer; taken when MemReady
//   MemReady                     : queue has a free slot
//   WriteAddr/Data/RegEn         : registered register-bank write port
//   Pending                      : one bit per register with a live queued load
//   Count                        : queue occupancy (live and killed slots)
// Macro WB_ZERO_DISCARD_EN: writes to register 0 are dropped on both paths.
// AW and DW must match the wb_pkg entry widths.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          AluValid,
    input  logic [AW-1:0]                 AluAddr,
    input  logic [DW-1:0]                 AluData,
    input  logic                          MemValid,
    input  logic [AW-1:0]                 MemAddr,
    input  logic [DW-1:0]                 MemData,
    output logic                          MemReady,
    output logic [AW-1:0]                 WriteAddr,
    output logic [DW-1:0]                 Data,
    output logic                          RegEn,
    output logic [(1<<AW)-1:0]            Pending,
    output logic [count_width(DEPTH)-1:0] Count
);

    localparam int CW = count_width(DEPTH);

    wb_entry_t                    push_entry;
    wb_entry_t                    head;
    logic                         push;
    logic                         pop;
    logic                         alu_write;
    logic [DEPTH-1:0]             q_live;
    logic [DEPTH-1:0][AW-1:0]     q_addr;

    assign MemReady = (Count != CW'(DEPTH));
    // ALU owns the write port whenever it is valid; the queue drains only when idle.
    assign pop      = !AluValid && (Count != '0);

`ifdef WB_ZERO_DISCARD_EN
    assign alu_write = AluValid && (AluAddr != '0);
    // r0 results still complete the handshake, they simply never enter the queue.
    assign push      = MemValid && MemReady && (MemAddr != '0);
`else
    assign alu_write = AluValid;
    assign push      = MemValid && MemReady;
`endif

    // A same-cycle ALU write to the same register is newer, so the entry arrives dead.
    always_comb begin
        push_entry      = '0;
        push_entry.live = !(AluValid && (MemAddr == AluAddr));
        push_entry.addr = MemAddr;
        push_entry.data = MemData;
    end

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (AluValid),
        .kill_addr  (AluAddr),
        .head       (head),
        .count      (Count),
        .live       (q_live),
        .addr       (q_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegEn     <= 1'b0;
            WriteAddr <= '0;
            Data      <= '0;
        end else if (AluValid) begin
            RegEn     <= alu_write;
            WriteAddr <= AluAddr;
            Data      <= AluData;
        end else if (pop) begin
            // A killed head still consumes its drain cycle, just without a write.
            RegEn     <= head.live;
            WriteAddr <= head.addr;
            Data      <= head.data;
        end else begin
            RegEn     <= 1'b0;
        end
    end

    always_comb begin
        Pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q_live[i]) begin
                Pending[q_addr[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef WB_ZERO_DISCARD_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 AluValid;
    logic [AW-1:0]        AluAddr;
    logic [DW-1:0]        AluData;
    logic                 MemValid;
    logic [AW-1:0]        MemAddr;
    logic [DW-1:0]        MemData;
    logic                 MemReady;
    logic [AW-1:0]        WriteAddr;
    logic [DW-1:0]        Data;
    logic                 RegEn;
    logic [(1<<AW)-1:0]   Pending;
    logic [CW-1:0]        Count;

    always #5 clk = ~clk;

    reg_writeback #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .AluValid  (AluValid),
        .AluAddr   (AluAddr),
        .AluData   (AluData),
        .MemValid  (MemValid),
        .MemAddr   (MemAddr),
        .MemData   (MemData),
        .MemReady  (MemReady),
        .WriteAddr (WriteAddr),
        .Data      (Data),
        .RegEn     (RegEn),
        .Pending   (Pending),
        .Count     (Count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order list of pending loads plus the expected write.
    typedef struct {
        bit          live;
        int unsigned addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    ent_t          e;
    bit            m_valid = 1'b0;
    bit            m_rst   = 1'b0;
    bit            m_en    = 1'b0;
    bit            m_acc   = 1'b0;
    int unsigned   m_addr  = 0;
    logic [DW-1:0] m_data  = '0;
    logic [31:0]   exp_pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_en    = 1'b0;
            m_addr  = 0;
            m_data  = '0;
            m_acc   = 1'b0;
            m_rst   = 1'b1;
            m_valid = 1'b1;
        end else begin
            m_rst = 1'b0;
            m_acc = MemValid && (q.size() < DEPTH);
            if (AluValid) begin
                foreach (q[i]) if (q[i].addr == AluAddr) q[i].live = 1'b0;
                m_en   = !(ZD && AluAddr == 0);
                m_addr = AluAddr;
                m_data = AluData;
            end else if (q.size() > 0) begin
                e      = q.pop_front();
                m_en   = e.live;
                m_addr = e.addr;
                m_data = e.data;
            end else begin
                m_en = 1'b0;
            end
            if (m_acc && !(ZD && MemAddr == 0)) begin
                e.live = !(AluValid && MemAddr == AluAddr);
                e.addr = MemAddr;
                e.data = MemData;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            exp_pend = '0;
            foreach (q[i]) if (q[i].live) exp_pend[q[i].addr] = 1'b1;
            chk("RegEn", RegEn, m_en);
            if (m_en || m_rst) begin
                chk("WriteAddr", WriteAddr, m_addr);
                chk("Data", Data, m_data);
            end
            chk("Count", Count, q.size());
            chk("Pending", Pending, exp_pend);
            chk("MemReady", MemReady, q.size() != DEPTH);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        AluValid = 1'b0;
        MemValid = 1'b0;
    endtask

    task automatic alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        AluValid = 1'b1;
        AluAddr  = a;
        AluData  = d;
    endtask

    task automatic mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        MemValid = 1'b1;
        MemAddr  = a;
        MemData  = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] order [5];
        order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
        rst_n = 1'b0;
        idle();
        AluAddr = '0; AluData = '0; MemAddr = '0; MemData = '0;
        step(); step();
        chk("rst_RegEn", RegEn, 0);
        chk("rst_WriteAddr", WriteAddr, 0);
        chk("rst_Data", Data, 0);
        chk("rst_Count", Count, 0);
        chk("rst_Pending", Pending, 0);
        chk("rst_MemReady", MemReady, 1);
        rst_n = 1'b1;

        // ALU write
        alu(5, 32'hDEADBEEF);
        step();
        chk("t1_RegEn", RegEn, 1);
        chk("t1_WriteAddr", WriteAddr, 5);
        chk("t1_Data", Data, 32'hDEADBEEF);
        idle();
        step();
        chk("t1_RegEn_off", RegEn, 0);

        // Memory write with ALU idle
        mem(7, 32'h11);
        step();
        chk("t2_Pending7_set", Pending[7], 1);
        MemValid = 1'b0;
        step();
        chk("t2_RegEn", RegEn, 1);
        chk("t2_WriteAddr", WriteAddr, 7);
        chk("t2_Data", Data, 32'h11);
        chk("t2_Pending7_clr", Pending[7], 0);

        // Fill while ALU busy, then drain in order
        alu(20, 32'h20);
        for (int k = 1; k <= 4; k++) begin
            mem(AW'(k), DW'(k));
            step();
        end
        chk("t3_Count_full", Count, 4);
        chk("t3_MemReady_full", MemReady, 0);
        mem(6, 32'h6);
        step();
        chk("t3_Count_held", Count, 4);
        AluValid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("t3_drain_RegEn", RegEn, 1);
            chk("t3_drain_WriteAddr", WriteAddr, order[j]);
            chk("t3_drain_Data", Data, DW'(order[j]));
            if (j == 1) MemValid = 1'b0;
        end
        step();

        // WAW kill
        alu(21, 32'h21);
        mem(9, 32'hAAAA);
        step();
        chk("t4_Pending9_set", Pending[9], 1);
        alu(9, 32'hBBBB);
        MemValid = 1'b0;
        step();
        chk("t4_RegEn", RegEn, 1);
        chk("t4_WriteAddr", WriteAddr, 9);
        chk("t4_Data", Data, 32'hBBBB);
        chk("t4_Pending9_clr", Pending[9], 0);
        chk("t4_Count_killed", Count, 1);
        idle();
        step();
        chk("t4_killed_RegEn", RegEn, 0);
        chk("t4_Count_empty", Count, 0);

        // Register 0
        alu(0, 32'h5);
        step();
`ifdef WB_ZERO_DISCARD_EN
        chk("t5_r0_RegEn", RegEn, 0);
`else
        chk("t5_r0_RegEn", RegEn, 1);
        chk("t5_r0_WriteAddr", WriteAddr, 0);
`endif
        idle();
        step();

        // Reset mid-drain
        alu(22, 32'h22);
        for (int k = 0; k < 3; k++) begin
            mem(AW'(10 + k), DW'(k));
            step();
        end
        chk("t6_Count_pre", Count, 3);
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_Count", Count, 0);
        chk("t6_Pending", Pending, 0);
        chk("t6_MemReady", MemReady, 1);
        chk("t6_RegEn", RegEn, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_no_write", RegEn, 0);
        end

        // Randomised traffic with small address range to force collisions
        for (int n = 0; n < 3000; n++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            AluValid = (((n / 300) % 2) != 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
            AluAddr  = AW'($urandom_range(0, 7));
            AluData  = $urandom;
            if (!(MemValid && !m_acc)) begin
                MemValid = ($urandom_range(0, 4) < 3);
                MemAddr  = AW'($urandom_range(0, 7));
                MemData  = $urandom;
            end
            step();
        end
        rst_n = 1'b1;
        idle();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back stage that drives the single write port of the register bank (`WriteAddr`, `Data`, `RegEn`). It accepts results from two producers:

- single-cycle ALU results, written immediately;
- multi-cycle memory/load results, buffered in a small in-order queue and drained when the ALU is idle.

It also exports a pending-register scoreboard so the hazard logic can stall readers of registers whose load has not yet been written back.

## Interface
Parameters:
- `DEPTH`, 4: memory-result queue entries (power of two, ≥2).
- `AW`, 5: register address width.
- `DW`, 32: data width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low (sampled on rising `clk`).
- `AluValid` in 1: ALU result present this cycle.
- `AluAddr` in AW: ALU destination register.
- `AluData` in DW: ALU result.
- `MemValid` in 1: memory result offered.
- `MemAddr` in AW: memory destination register.
- `MemData` in DW: memory result.
- `MemReady` out 1: queue can accept; a transfer happens when `MemValid && MemReady`.
- `WriteAddr` out AW: register bank write address.
- `Data` out DW: register bank write data.
- `RegEn` out 1: register bank write enable.
- `Pending` out 2^AW: bit r = 1 while a live queued entry targets register r.
- `Count` out $clog2(DEPTH+1): queue occupancy, counting live and killed entries.

## Operation
- **Outputs are registered.** `WriteAddr`, `Data` and `RegEn` update on the rising edge.
- **ALU path.** `AluValid` at cycle N produces a write at cycle N+1. The ALU has absolute priority over the queue and never stalls.
- **Memory path.**
  - An accepted entry is stored as {live=1, addr, data} at the tail.
  - `MemReady = (Count != DEPTH)`. It is combinational from registered state and does not depend on `MemValid`.
  - When full, the producer holds `MemValid`, `MemAddr` and `MemData` stable until accepted.
- **Drain.** In any cycle with `AluValid=0` and `Count>0`, the head entry is popped.
  - Live head: it is presented on the write port next cycle.
  - Killed head: it is popped with `RegEn=0` next cycle, which consumes the slot.
- **Ordering (WAW).** An ALU result is always newer than every queued memory result.
  - When `AluValid` is high, every live queued entry with addr == `AluAddr` is marked killed in that cycle.
  - A memory entry accepted in the same cycle with `MemAddr == AluAddr` is enqueued already killed.
- **Scoreboard.** `Pending` is the combinational OR over live entries of the one-hot decode of their address.
  - A bit clears on the cycle after the last live entry for that register is popped or killed.
  - Duplicate queued addresses keep the bit set until all of them are gone.
- **Simultaneous enqueue and drain** at `Count==DEPTH`: `MemReady` is 0, so no enqueue occurs that cycle. There is no same-cycle pass-through.
- **Pointers.** Head and tail wrap modulo DEPTH. `Count` distinguishes full from empty.

## Timing
- Reset values: `RegEn`=0, `WriteAddr`=0, `Data`=0, `Count`=0, `Pending`=0, `MemReady`=1. All entries are not-live and both pointers are 0.
- ALU latency: 1 cycle, input to `RegEn`.
- Memory latency: minimum 2 cycles, acceptance to `RegEn` (1 cycle enqueue + 1 cycle drain register). Each ALU-busy cycle adds 1 cycle.
- Throughput: one write per cycle in total across both sources.
- Reset mid-operation: queued entries are discarded and never written. `RegEn` is 0 in the cycle following the reset edge.

## Configuration
- `WB_ZERO_DISCARD_EN` defined:
  - Writes targeting address 0 are dropped on both paths.
  - An ALU write to r0 gives `RegEn`=0 but still kills queued r0 entries.
  - Memory r0 results are accepted (handshake completes) but are not enqueued. `Count` and `Pending[0]` are unchanged.
- Undefined: address 0 is an ordinary register.

## Structure
- Package `wb_pkg`:
  - defaults for `DEPTH`, `AW`, `DW`;
  - packed struct `wb_entry_t` {live, addr, data};
  - the `Count` width function.
- Sub-module `wb_queue`: circular queue of `wb_entry_t` with push, pop and a kill-by-address port. It exports per-entry live and addr so the top can build `Pending`.
- Top: ALU/queue arbitration, kill generation, registered write port, scoreboard decode.

## Test plan
1. **ALU write.** `AluValid`, r5=0xDEADBEEF at cycle 0 → cycle 1: `RegEn`=1, `WriteAddr`=5, `Data`=0xDEADBEEF. Cycle 2: `RegEn`=0.
2. **Memory write, ALU idle.** r7=0x11 accepted at cycle 0 → `Pending[7]`=1 from cycle 1. Cycle 2: `RegEn`=1, `WriteAddr`=7, `Data`=0x11. `Pending[7]`=0 from cycle 2.
3. **Full and drain in order.** Hold `AluValid`=1 and push r1–r4 = 0x1..0x4 → `Count`=4, `MemReady`=0, and the 5th offer (r6) is held. Drop `AluValid` → r1, r2, r3, r4, r6 are written on consecutive cycles, in that order.
4. **WAW kill.** Queue r9=0xAAAA, then ALU r9=0xBBBB → only 0xBBBB is written to r9. `Pending[9]`=0 the cycle after the ALU write. The killed slot drains with `RegEn`=0.
5. **Register 0.** ALU r0=0x5 with the macro defined → no `RegEn`. Without the macro → `RegEn`=1, `WriteAddr`=0.
6. **Reset mid-drain.** 3 entries queued, `rst_n`=0 for one edge → `Count`=0, `Pending`=0, `MemReady`=1. No further writes occur.
